// File: rtl/spi_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_rx_deser: SPI slave MOSI deserialiser with valid/ack and sticky errors |
// | Optional even-parity frame bit: SPI_RX_PARITY_EN.  Rev 1.0                 |
// +----------------------------------------------------------------------------+
module spi_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sampl_en,
  input  logic                  mosi,
  input  logic                  lsb_first,
  input  logic                  rd_ack,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  parity_err
);

`ifdef SPI_RX_PARITY_EN
  localparam int c_FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int c_FRAME_LEN = DATA_WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(c_FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] r_sh;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [CNT_WIDTH-1:0]  r_bit_cnt;
  logic                  r_mode;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic                  w_sample;
  logic                  w_mode;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_sh_next;
  logic [DATA_WIDTH-1:0] w_word;

  always_comb begin
    w_sample  = ~cs_n & sampl_en;
    // First bit of a word uses the live lsb_first; later bits use the latched mode.
    w_mode    = (r_bit_cnt == '0) ? lsb_first : r_mode;
    w_last    = w_sample & (r_bit_cnt == c_LAST);
    w_sh_next = w_mode ? {mosi, r_sh[DATA_WIDTH-1:1]} : {r_sh[DATA_WIDTH-2:0], mosi};
`ifdef SPI_RX_PARITY_EN
    w_word    = r_sh;
`else
    w_word    = w_sh_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh        <= '0;
      r_data_out  <= '0;
      r_bit_cnt   <= '0;
      r_mode      <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (cs_n) begin
        r_bit_cnt <= '0;
        r_sh      <= '0;
      end else if (w_sample) begin
        if (r_bit_cnt == '0)
          r_mode <= lsb_first;
        if (w_last) begin
          r_bit_cnt  <= '0;
          r_sh       <= '0;
          r_data_out <= w_word;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
          r_sh      <= w_sh_next;
        end
      end

      if (w_last)
        r_valid <= 1'b1;
      else if (rd_ack)
        r_valid <= 1'b0;

      // Set conditions take priority over err_clr.
      if (w_last && r_valid && !rd_ack)
        r_overrun <= 1'b1;
      else if (err_clr)
        r_overrun <= 1'b0;

      if (cs_n && (r_bit_cnt != '0))
        r_frame_err <= 1'b1;
      else if (err_clr)
        r_frame_err <= 1'b0;
    end
  end

`ifdef SPI_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_parity_err <= 1'b0;
    else if (w_last && ((^r_sh) ^ mosi))
      r_parity_err <= 1'b1;
    else if (err_clr)
      r_parity_err <= 1'b0;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign bit_cnt    = r_bit_cnt;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_rx_deser: directed self-checking bench for spi_rx_deser (W=8)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_rx_deser;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 6;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cs_n;
  logic                  sampl_en;
  logic                  mosi;
  logic                  lsb_first;
  logic                  rd_ack;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  overrun;
  logic                  frame_err;
  logic                  parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  spi_rx_deser #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sampl_en   (sampl_en),
    .mosi       (mosi),
    .lsb_first  (lsb_first),
    .rd_ack     (rd_ack),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample strobe; returns on the following falling edge so results are visible.
  task automatic strobe(input logic b, input logic ack);
    @(negedge clk);
    mosi     = b;
    sampl_en = 1'b1;
    rd_ack   = ack;
    @(negedge clk);
    sampl_en = 1'b0;
    rd_ack   = 1'b0;
  endtask

  // Sends bits [first, first+n) of the word in the given order.
  task automatic send_bits(input logic [7:0] d, input logic lsb, input int first, input int n);
    for (int i = first; i < first + n; i++)
      strobe(lsb ? d[i] : d[7-i], 1'b0);
  endtask

  // Full frame; ack_last raises rd_ack on the completing strobe.
  task automatic send_word(input logic [7:0] d, input logic lsb, input logic ack_last);
`ifdef SPI_RX_PARITY_EN
    send_bits(d, lsb, 0, 8);
    strobe(^d, ack_last);
`else
    send_bits(d, lsb, 0, 7);
    strobe(lsb ? d[7] : d[0], ack_last);
`endif
  endtask

  task automatic pulse_ack();
    @(negedge clk); rd_ack = 1'b1;
    @(negedge clk); rd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sampl_en = 1'b0; mosi = 1'b0;
    lsb_first = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",   32'(data_out),   32'h0);
    chk("rst_valid",  32'(data_valid), 32'h0);
    chk("rst_cnt",    32'(bit_cnt),    32'h0);
    chk("rst_ovr",    32'(overrun),    32'h0);
    chk("rst_frame",  32'(frame_err),  32'h0);
    chk("rst_parity", 32'(parity_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;

    // MSB-first 0xA5
    send_bits(8'hA5, 1'b0, 0, 7);
    chk("msb_cnt7",   32'(bit_cnt),    32'd7);
    chk("msb_pre_v",  32'(data_valid), 32'h0);
    send_bits(8'hA5, 1'b0, 7, 1);
`ifdef SPI_RX_PARITY_EN
    strobe(1'b0, 1'b0);
`endif
    chk("msb_data",   32'(data_out),   32'hA5);
    chk("msb_valid",  32'(data_valid), 32'h1);
    chk("msb_cnt0",   32'(bit_cnt),    32'h0);
    pulse_ack();
    chk("ack_clear",  32'(data_valid), 32'h0);

    // LSB-first 0xA5, lsb_first toggled after bit 3 must be ignored
    lsb_first = 1'b1;
    send_bits(8'hA5, 1'b1, 0, 3);
    lsb_first = 1'b0;
    send_bits(8'hA5, 1'b1, 3, 5);
`ifdef SPI_RX_PARITY_EN
    strobe(1'b0, 1'b0);
`endif
    chk("lsb_data",   32'(data_out),   32'hA5);
    chk("lsb_valid",  32'(data_valid), 32'h1);
    pulse_ack();

    // Overrun without ack, then err_clr
    send_word(8'h3C, 1'b0, 1'b0);
    chk("ovr_first",  32'(overrun),    32'h0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("ovr_data",   32'(data_out),   32'hC3);
    chk("ovr_valid",  32'(data_valid), 32'h1);
    chk("ovr_set",    32'(overrun),    32'h1);
    pulse_clr();
    chk("ovr_clr",    32'(overrun),    32'h0);
    chk("ovr_clr_v",  32'(data_valid), 32'h1);
    pulse_ack();

    // Completion coincident with rd_ack: no overrun, valid stays set
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b1);
    chk("sim_data",   32'(data_out),   32'hC3);
    chk("sim_valid",  32'(data_valid), 32'h1);
    chk("sim_ovr",    32'(overrun),    32'h0);
    pulse_ack();
    chk("sim_ack",    32'(data_valid), 32'h0);

    // Framing error after 5 bits, then a clean word
    send_bits(8'h5A, 1'b0, 0, 5);
    chk("frm_cnt5",   32'(bit_cnt),    32'd5);
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk); cs_n = 1'b0;
    chk("frm_set",    32'(frame_err),  32'h1);
    chk("frm_cnt0",   32'(bit_cnt),    32'h0);
    chk("frm_data",   32'(data_out),   32'hC3);
    chk("frm_valid",  32'(data_valid), 32'h0);
    send_word(8'h81, 1'b0, 1'b0);
    chk("frm_next",   32'(data_out),   32'h81);
    chk("frm_sticky", 32'(frame_err),  32'h1);
    pulse_clr();
    chk("frm_clr",    32'(frame_err),  32'h0);
    pulse_ack();

    // Async reset mid-word, then 0xFF
    send_bits(8'h0F, 1'b0, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_d",  32'(data_out),   32'h0);
    chk("mid_rst_c",  32'(bit_cnt),    32'h0);
    chk("mid_rst_v",  32'(data_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    send_word(8'hFF, 1'b0, 1'b0);
    chk("post_rst_d", 32'(data_out),   32'hFF);
    chk("post_rst_v", 32'(data_valid), 32'h1);
    chk("post_rst_f", 32'(frame_err),  32'h0);
    pulse_ack();

`ifdef SPI_RX_PARITY_EN
    send_bits(8'h07, 1'b0, 0, 8);
    strobe(1'b1, 1'b0);
    chk("par_ok",     32'(parity_err), 32'h0);
    pulse_ack();
    send_bits(8'h07, 1'b0, 0, 8);
    strobe(1'b0, 1'b0);
    chk("par_bad",    32'(parity_err), 32'h1);
    chk("par_data",   32'(data_out),   32'h07);
    chk("par_valid",  32'(data_valid), 32'h1);
`else
    chk("par_tied",   32'(parity_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rx_deser.md
Name: spi_rx_deser

Overview:
Parametrised SPI slave receive deserialiser, the successor to the fixed single-shift MOSI receiver. It samples MOSI on qualified sample strobes while chip select is active. Word width and bit order are configurable. Each completed word is presented on a valid/acknowledge handshake, with sticky overrun and framing-error flags. It sits between the SPI edge-detect/sampler logic and the slave register file or RX FIFO.

Parameters:
DATA_WIDTH, 8, bits per word; legal range 2..32.
CNT_WIDTH, 6, bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH+1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
cs_n  input  1  chip select, active low, synchronous to clk.
sampl_en  input  1  one-cycle sample strobe from the SCLK edge detector.
mosi  input  1  serial data, synchronous to clk.
lsb_first  input  1  bit order: 0 = MSB first, 1 = LSB first.
rd_ack  input  1  consumer acknowledge of the current word.
err_clr  input  1  clears sticky error flags.
data_out  output  DATA_WIDTH  last completed word.
data_valid  output  1  word available; level-held until acknowledged.
bit_cnt  output  CNT_WIDTH  bits received in the current word.
overrun  output  1  sticky: a word completed while the previous word was unacknowledged.
frame_err  output  1  sticky: cs_n deasserted mid-word.
parity_err  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset (async): shift register, data_out, bit_cnt, mode_q = 0; data_valid, overrun, frame_err, parity_err = 0.
- Sample event: cs_n==0 && sampl_en==1. No state changes when cs_n==0 && sampl_en==0.
- Bit order is captured into mode_q on the sample event with bit_cnt==0. It is held constant for the rest of the word; lsb_first changes mid-word are ignored.
- Shifting on a sample event:
  - mode_q==0 (MSB first): sh <= {sh[W-2:0], mosi}.
  - mode_q==1 (LSB first): sh <= {mosi, sh[W-1:1]}.
  - For the first bit, the current lsb_first value is used directly.
- bit_cnt increments on each sample event. On the sample event with bit_cnt==FRAME_LEN-1:
  - bit_cnt wraps to 0.
  - data_out is loaded with the assembled word, including the current bit.
  - data_valid is set.
  - FRAME_LEN = DATA_WIDTH (DATA_WIDTH+1 with parity).
- Latency: data_out and data_valid update on the clock edge that samples the final bit, so they are visible in the following cycle.
- Handshake:
  - rd_ack while data_valid==1 clears data_valid on the next edge.
  - rd_ack while data_valid==0 is ignored.
- Simultaneous completion and rd_ack: new word loads, data_valid stays 1, no overrun.
- Completion with data_valid==1 and no rd_ack: data_out is overwritten with the new word, data_valid stays 1, overrun is set.
- cs_n==1 (any cycle): bit_cnt <= 0, sh <= 0. data_out and data_valid are retained, and rd_ack still works.
- frame_err is set on any cycle with cs_n==1 and bit_cnt!=0. The partial word is discarded and data_valid is not set.
- err_clr clears overrun, frame_err and parity_err. If a set condition occurs in the same cycle, the set wins.
- Words back-to-back without a cs_n toggle are legal; counting continues from 0.
- Reset mid-word: all state returns to reset values immediately, with no partial word emitted.

Optional Feature:
Macro SPI_RX_PARITY_EN.
- Defined:
  - FRAME_LEN = DATA_WIDTH+1; the extra final bit is an even-parity bit over the data bits and is not shifted into sh.
  - On completion, parity_err is set if XOR(data bits, parity bit)==1. data_out and data_valid still update.
  - cs_n rising with bit_cnt==DATA_WIDTH (only the parity bit missing) sets frame_err.
- Not defined: FRAME_LEN = DATA_WIDTH and parity_err is tied to 0.

Test Plan:
- W=8, lsb_first=0, cs_n low, shift 0xA5 MSB first -> data_out=0xA5, data_valid=1 one cycle after the 8th strobe, bit_cnt=0.
- lsb_first=1, shift 0xA5 LSB first (bits 1,0,1,0,0,1,0,1) -> data_out=0xA5. Toggling lsb_first after bit 3 has no effect.
- Two words 0x3C, 0xC3 with no rd_ack -> data_out=0xC3, data_valid=1, overrun=1. Then err_clr -> overrun=0. Repeat with rd_ack on the completion cycle -> overrun stays 0.
- cs_n raised after 5 bits -> frame_err=1, bit_cnt=0, data_out unchanged. The next full word 0x81 receives correctly.
- Assert rst_n low after 4 bits of a word -> all outputs 0. After release, 0xFF receives correctly.
- With SPI_RX_PARITY_EN: 0x07 + parity 1 -> parity_err=0. 0x07 + parity 0 -> parity_err=1, data_out=0x07, data_valid=1.
